// File: rtl/fp_seq_multiplier_if.sv
// rtl/fp_seq_multiplier_if.sv - operand/start and result/flag bundle for fp_seq_multiplier
interface fp_seq_multiplier_if #(
  parameter int X = 32
);
  logic [X-1:0] a;
  logic [X-1:0] b;
  logic         start;
  logic [X-1:0] q;
  logic         ready;
  logic         busy;
  logic         overflow;
  logic         underflow;
  logic         invalid;

  modport master (
    output a, b, start,
    input  q, ready, busy, overflow, underflow, invalid
  );

  modport slave (
    input  a, b, start,
    output q, ready, busy, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_seq_multiplier.sv
// rtl/fp_seq_multiplier.sv - iterative IEEE-754 multiplier, radix-2 shift-and-add
// FPMUL_RNE_EN selects round-to-nearest-even; otherwise the product is truncated.
module fp_seq_multiplier #(
  parameter int X = 32
) (
  input  logic               clk,
  input  logic               clr,
  fp_seq_multiplier_if.slave bus
);
  localparam int EB   = (X == 64) ? 11 : 8;
  localparam int MB   = (X == 64) ? 52 : 23;
  localparam int BIAS = (X == 64) ? 1023 : 127;
  localparam int SW   = MB + 1;
  localparam int EW   = EB + 2;
  localparam int CW   = $clog2(SW + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_MULT   = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;

  localparam logic [X-1:0] QNAN = {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};

  logic [2:0]      r_state;
  logic [X-1:0]    r_a;
  logic [X-1:0]    r_b;
  logic            r_sign;
  logic [EW-1:0]   r_e;
  logic [SW-1:0]   r_ma;
  logic [SW-1:0]   r_mb;
  logic [2*SW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [MB-1:0]   r_mant;
  logic            r_g;
  logic            r_r;
  logic            r_s;
  logic [X-1:0]    r_q;
  logic            r_ready;
  logic            r_busy;
  logic            r_ovf;
  logic            r_unf;
  logic            r_inv;

  logic [EB-1:0]   w_ea;
  logic [EB-1:0]   w_eb;
  logic [MB-1:0]   w_fa;
  logic [MB-1:0]   w_fb;
  logic            w_a_zero;
  logic            w_b_zero;
  logic            w_a_inf;
  logic            w_b_inf;
  logic            w_a_nan;
  logic            w_b_nan;
  logic            w_sign;
  logic [EW-1:0]   w_e_sum;
  logic            w_is_nan;
  logic            w_is_inf;
  logic            w_is_zero;

  logic [SW-1:0]   w_addend;
  logic [SW:0]     w_upper;
  logic [2*SW-1:0] w_acc_next;
  logic [2*SW-1:0] w_pn;

  logic            w_inc;
  logic [MB:0]     w_rsum;
  logic [EW-1:0]   w_e_fin;
  logic            w_ovf;
  logic            w_unf;

  // Subnormals have a zero exponent field, so FTZ falls out of the zero test.
  assign w_ea     = r_a[X-2:MB];
  assign w_eb     = r_b[X-2:MB];
  assign w_fa     = r_a[MB-1:0];
  assign w_fb     = r_b[MB-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (|w_fa);
  assign w_b_nan  = (&w_eb) && (|w_fb);
  assign w_sign   = r_a[X-1] ^ r_b[X-1];
  assign w_e_sum  = {2'b00, w_ea} + {2'b00, w_eb} - EW'(BIAS);

  assign w_is_nan  = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf);
  assign w_is_inf  = w_a_inf || w_b_inf;
  assign w_is_zero = w_a_zero || w_b_zero;

  assign w_addend   = r_mb[0] ? r_ma : '0;
  assign w_upper    = {1'b0, r_acc[2*SW-1:SW]} + {1'b0, w_addend};
  assign w_acc_next = {w_upper, r_acc[SW-1:1]};

  // Left-justify so the leading 1 sits in the MSB; no product bits are lost.
  assign w_pn = r_acc[2*SW-1] ? r_acc : {r_acc[2*SW-2:0], 1'b0};

`ifdef FPMUL_RNE_EN
  assign w_inc = r_g & (r_r | r_s | r_mant[0]);
`else
  assign w_inc = 1'b0 & r_g & (r_r | r_s);
`endif

  assign w_rsum  = {1'b0, r_mant} + {{MB{1'b0}}, w_inc};
  assign w_e_fin = r_e + {{(EW-1){1'b0}}, w_rsum[MB]};
  assign w_ovf   = !w_e_fin[EW-1] && (w_e_fin >= EW'((1 << EB) - 1));
  assign w_unf   = w_e_fin[EW-1] || (w_e_fin == '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_e     <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_mant  <= '0;
      r_g     <= 1'b0;
      r_r     <= 1'b0;
      r_s     <= 1'b0;
      r_q     <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_inv   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_inv   <= 1'b0;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_sign <= w_sign;
          r_e    <= w_e_sum;
          r_ma   <= {1'b1, w_fa};
          r_mb   <= {1'b1, w_fb};
          r_acc  <= '0;
          r_cnt  <= CW'(SW);
          if (w_is_nan || w_is_inf || w_is_zero) begin
            if (w_is_nan) begin
              r_q   <= QNAN;
              r_inv <= 1'b1;
            end else if (w_is_inf) begin
              r_q <= {w_sign, {EB{1'b1}}, {MB{1'b0}}};
            end else begin
              r_q <= {w_sign, {(X-1){1'b0}}};
            end
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_MULT;
          end
        end
        S_MULT: begin
          r_acc <= w_acc_next;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_mant  <= w_pn[2*MB:MB+1];
          r_g     <= w_pn[MB];
          r_r     <= w_pn[MB-1];
          r_s     <= |w_pn[MB-2:0];
          r_e     <= r_e + {{(EW-1){1'b0}}, r_acc[2*SW-1]};
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          // A rounding carry leaves w_rsum[MB-1:0] all zero, which is the renormalized mantissa.
          if (w_ovf) begin
            r_q   <= {r_sign, {EB{1'b1}}, {MB{1'b0}}};
            r_ovf <= 1'b1;
          end else if (w_unf) begin
            r_q   <= {r_sign, {(X-1){1'b0}}};
            r_unf <= 1'b1;
          end else begin
            r_q <= {r_sign, w_e_fin[EB-1:0], w_rsum[MB-1:0]};
          end
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q         = r_q;
  assign bus.ready     = r_ready;
  assign bus.busy      = r_busy;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
  assign bus.invalid   = r_inv;
endmodule

// File: tb/tb_fp_seq_multiplier.sv
// tb/tb_fp_seq_multiplier.sv - scoreboard bench for fp_seq_multiplier (X=32)
module tb_fp_seq_multiplier;
  logic clk = 1'b0;
  logic clr = 1'b1;

  fp_seq_multiplier_if #(.X(32)) bus ();

  fp_seq_multiplier #(.X(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [2:0]  flags;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

`ifdef FPMUL_RNE_EN
  localparam logic [31:0] RND_Q = 32'h40100002;
`else
  localparam logic [31:0] RND_Q = 32'h40100001;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [31:0] ia, input logic [31:0] ib);
    bus.a     = ia;
    bus.b     = ib;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] eq,
                       input logic [2:0] ef, input int el, input string tag);
    exp_t e;
    e.q = eq; e.flags = ef; e.lat = el; e.tag = tag;
    sb.push_back(e);
    drive_start(ia, ib);
    check({tag, "_accept"}, 64'({bus.busy, bus.ready}), 64'(2'b10));
  endtask

  task automatic collect(input int n0);
    exp_t e;
    int n;
    logic busy_ok;
    n = n0;
    busy_ok = 1'b1;
    while (bus.ready !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (bus.ready !== 1'b1 && bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    if (sb.size() == 0) begin
      check("sb_underrun", 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      check({e.tag, "_lat"}, 64'(n), 64'(e.lat));
      check({e.tag, "_q"}, 64'(bus.q), 64'(e.q));
      check({e.tag, "_flags"}, 64'({bus.overflow, bus.underflow, bus.invalid}), 64'(e.flags));
      check({e.tag, "_busy"}, 64'({bus.busy, busy_ok}), 64'(2'b01));
    end
  endtask

  task automatic op(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] eq,
                    input logic [2:0] ef, input int el, input string tag);
    issue(ia, ib, eq, ef, el, tag);
    collect(0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_q;
    logic        saw_ready;
    bus.a = '0;
    bus.b = '0;
    bus.start = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    check("reset_out", 64'({bus.q, bus.ready, bus.busy, bus.overflow, bus.underflow, bus.invalid}), 64'(0));

    op(32'h40400000, 32'h40200000, 32'h40F00000, 3'b000, 27, "mul_3x2p5");
    held_q = bus.q;
    repeat (3) tick();
    check("hold", 64'({bus.q, bus.ready, bus.busy}), 64'({held_q, 2'b10}));

    op(32'h3F800000, 32'hBF800000, 32'hBF800000, 3'b000, 27, "one_x_neg1");
    op(32'h00000000, 32'hC0000000, 32'h80000000, 3'b000, 1,  "zero_x_neg2");
    op(32'h3FC00001, 32'h3FC00001, RND_Q,        3'b000, 27, "round");
    op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 27, "norm_shift");
    op(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000, 27, "max_mant");
    op(32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, 27, "ovf");
    op(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100, 27, "ovf_edge");
    op(32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000, 27, "emax_ok");
    op(32'h00800000, 32'h00800000, 32'h00000000, 3'b010, 27, "unf");
    op(32'h80800000, 32'h00800000, 32'h80000000, 3'b010, 27, "unf_neg");
    op(32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 27, "unf_edge");
    op(32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, 27, "emin_ok");
    op(32'h00400000, 32'h40000000, 32'h00000000, 3'b000, 1,  "ftz_sub");
    op(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 1,  "inf_x_zero");
    op(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b001, 1,  "nan_in");
    op(32'hC0000000, 32'hFF800000, 32'h7F800000, 3'b000, 1,  "neg_x_ninf");
    op(32'h7F800000, 32'hFF800000, 32'hFF800000, 3'b000, 1,  "inf_x_ninf");

    issue(32'h40400000, 32'h40200000, 32'h40F00000, 3'b000, 27, "busy_start");
    repeat (4) tick();
    drive_start(32'h3F800000, 32'h3F800000);
    collect(5);

    drive_start(32'h40400000, 32'h40200000);
    repeat (9) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("midop_reset", 64'({bus.q, bus.ready, bus.busy, bus.overflow, bus.underflow, bus.invalid}), 64'(0));
    saw_ready = 1'b0;
    repeat (40) begin
      tick();
      if (bus.ready === 1'b1 || bus.busy === 1'b1) saw_ready = 1'b1;
    end
    check("no_ready_after_reset", 64'(saw_ready), 64'(0));

    op(32'h40000000, 32'h40000000, 32'h40800000, 3'b000, 27, "restart_2x2");

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
